// File: rtl/pc_seq_ctrl_if.sv
// Handshake and status bundle between the PC sequencer and its environment.
// The slave modport is the sequencer side; the master modport drives the
// control inputs and observes the sequencer outputs.
interface pc_seq_ctrl_if #(
    parameter int unsigned N = 32
);
    logic         start;
    logic         halt;
    logic         stall;
    logic         imem_ack;
    logic         br_taken;
    logic         jal;
    logic         jalr;
    logic         imem_req;
    logic         ir_load;
    logic [1:0]   pcsel;
    logic         pc_en;
    logic         busy;
    logic         fault;
    logic [N-1:0] retired;

    modport master (
        output start, halt, stall, imem_ack, br_taken, jal, jalr,
        input  imem_req, ir_load, pcsel, pc_en, busy, fault, retired
    );

    modport slave (
        input  start, halt, stall, imem_ack, br_taken, jal, jalr,
        output imem_req, ir_load, pcsel, pc_en, busy, fault, retired
    );
endinterface

// File: rtl/pc_seq_ctrl.sv
// Multi-cycle program-counter sequencer: fetch / decode / execute / update,
// with instruction-memory handshake, next-PC source selection, a sticky
// fetch-timeout fault and a wrapping retired-instruction counter.
module pc_seq_ctrl #(
    parameter int unsigned n       = 32,
    parameter int unsigned MAXWAIT = 15
) (
    input logic          clock,
    input logic          reset,
    pc_seq_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        UPDATE,
        FAULT
    } state_t;

    localparam logic [3:0] MAXW = 4'(MAXWAIT);

    state_t       state;
    state_t       next_state;
    logic [3:0]   wait_cnt;
    logic [1:0]   pcsel_q;
    logic [1:0]   sel_d;
    logic [n-1:0] retired_q;
    logic         busy_q;
    logic         imem_req_c;
    logic         ir_load_c;
    logic         pc_en_c;
    logic         fault_c;

    // State register; reset forces IDLE so every state-decoded strobe drops at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode, redirect priority and state-decoded strobes.
    always_comb begin
        next_state = state;
        imem_req_c = 1'b0;
        ir_load_c  = 1'b0;
        pc_en_c    = 1'b0;
        fault_c    = 1'b0;

        if (bus.jalr) begin
            sel_d = 2'b11;
        end else if (bus.jal) begin
            sel_d = 2'b10;
        end else if (bus.br_taken) begin
            sel_d = 2'b01;
        end else begin
            sel_d = 2'b00;
        end

        case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ack) begin
                    ir_load_c  = 1'b1;
                    next_state = DECODE;
                end else if (wait_cnt == MAXW - 4'd1) begin
                    // This is the MAXWAIT-th unanswered cycle.
                    next_state = FAULT;
                end
            end
            DECODE: begin
                if (!bus.stall) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                if (!bus.stall) begin
                    next_state = UPDATE;
                end
            end
            UPDATE: begin
                pc_en_c    = 1'b1;
                next_state = bus.halt ? IDLE : FETCH;
            end
            FAULT: begin
                fault_c = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Fetch wait counter: counts unanswered FETCH cycles, zero everywhere else.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == FETCH && !bus.imem_ack) begin
            wait_cnt <= wait_cnt + 4'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Next-PC select register, loaded only when EXEC completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pcsel_q <= '0;
        end else if (state == EXEC && !bus.stall) begin
            pcsel_q <= sel_d;
        end
    end

    // Retired counter advances once per UPDATE and wraps naturally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
        end else if (state == UPDATE) begin
            retired_q <= retired_q + 1'b1;
        end
    end

    // Busy is registered from the state being entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= (next_state != IDLE) && (next_state != FAULT);
        end
    end

    assign bus.imem_req = imem_req_c;
    assign bus.ir_load  = ir_load_c;
    assign bus.pc_en    = pc_en_c;
    assign bus.fault    = fault_c;
    assign bus.pcsel    = pcsel_q;
    assign bus.busy     = busy_q;
    assign bus.retired  = retired_q;
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: per-cycle vector table plus hand-built
// sequences for timeout, async reset and counter wrap; a queue scoreboard
// checks pcsel and retired whenever pc_en fires.
module tb_pc_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    pc_seq_ctrl_if #(.N(4)) bus ();

    pc_seq_ctrl #(.n(4), .MAXWAIT(15)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, ha, sl, ak, br, jl, jr;
        logic       req, irl, pce;
        logic [1:0] sel;
        logic       bsy, flt;
        logic       push;
        logic [1:0] pval;
    } vec_t;

    int         compared   = 0;
    int         mismatched = 0;
    logic [1:0] sb_q[$];
    logic [3:0] exp_ret;
    logic [1:0] cur_sel;
    vec_t       tbl[31];

    function automatic vec_t mk(input logic st, ha, sl, ak, br, jl, jr,
                                input logic req, irl, pce,
                                input logic [1:0] sel,
                                input logic bsy, flt, push,
                                input logic [1:0] pval);
        vec_t r;
        r.st = st; r.ha = ha; r.sl = sl; r.ak = ak;
        r.br = br; r.jl = jl; r.jr = jr;
        r.req = req; r.irl = irl; r.pce = pce; r.sel = sel;
        r.bsy = bsy; r.flt = flt; r.push = push; r.pval = pval;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_check(input string tag);
        logic [1:0] e;
        if (bus.pc_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL %s.sb_underflow: got pc_en=1 expected no update", tag);
            end else begin
                e = sb_q.pop_front();
                chk({tag, ".sb_pcsel"}, 32'(bus.pcsel), 32'(e));
                chk({tag, ".sb_retired"}, 32'(bus.retired), 32'(exp_ret));
                exp_ret = exp_ret + 4'd1;
            end
        end
    endtask

    task automatic step(input vec_t r, input string tag);
        @(negedge clk);
        bus.start    = r.st;
        bus.halt     = r.ha;
        bus.stall    = r.sl;
        bus.imem_ack = r.ak;
        bus.br_taken = r.br;
        bus.jal      = r.jl;
        bus.jalr     = r.jr;
        #1;
        chk({tag, ".imem_req"}, 32'(bus.imem_req), 32'(r.req));
        chk({tag, ".ir_load"},  32'(bus.ir_load),  32'(r.irl));
        chk({tag, ".pc_en"},    32'(bus.pc_en),    32'(r.pce));
        chk({tag, ".pcsel"},    32'(bus.pcsel),    32'(r.sel));
        chk({tag, ".busy"},     32'(bus.busy),     32'(r.bsy));
        chk({tag, ".fault"},    32'(bus.fault),    32'(r.flt));
        if (r.push) sb_q.push_back(r.pval);
        sb_check(tag);
    endtask

    // Asserts reset wherever the caller currently is in the cycle, checks that
    // everything clears without a clock edge, then releases on a falling edge.
    task automatic async_reset(input string tag);
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.halt     = 1'b0;
        bus.stall    = 1'b0;
        bus.imem_ack = 1'b0;
        bus.br_taken = 1'b0;
        bus.jal      = 1'b0;
        bus.jalr     = 1'b0;
        #1;
        chk({tag, ".rst_imem_req"}, 32'(bus.imem_req), 32'd0);
        chk({tag, ".rst_ir_load"},  32'(bus.ir_load),  32'd0);
        chk({tag, ".rst_pc_en"},    32'(bus.pc_en),    32'd0);
        chk({tag, ".rst_pcsel"},    32'(bus.pcsel),    32'd0);
        chk({tag, ".rst_busy"},     32'(bus.busy),     32'd0);
        chk({tag, ".rst_fault"},    32'(bus.fault),    32'd0);
        chk({tag, ".rst_retired"},  32'(bus.retired),  32'd0);
        @(negedge clk);
        rst     = 1'b0;
        sb_q.delete();
        exp_ret = '0;
        cur_sel = '0;
    endtask

    // One full instruction with immediate ack; decoy flags are driven while
    // EXEC is stalled and must not be sampled.
    task automatic run_instr(input logic br, jl, jr, input int unsigned nstall,
                             input logic ha, input logic from_idle, input string tag);
        logic [1:0] e;
        e = jr ? 2'b11 : (jl ? 2'b10 : (br ? 2'b01 : 2'b00));
        if (from_idle)
            step(mk(1,0,0,0,0,0,0, 0,0,0,cur_sel,0,0, 0,2'd0), {tag, ".idle"});
        step(mk(0,0,0,1,0,0,0, 1,1,0,cur_sel,1,0, 0,2'd0), {tag, ".fetch"});
        step(mk(0,0,0,0,0,0,0, 0,0,0,cur_sel,1,0, 0,2'd0), {tag, ".decode"});
        for (int unsigned i = 0; i < nstall; i++)
            step(mk(0,0,1,0,~br,~jl,~jr, 0,0,0,cur_sel,1,0, 0,2'd0), {tag, ".stall"});
        step(mk(0,0,0,0,br,jl,jr, 0,0,0,cur_sel,1,0, 1,e), {tag, ".exec"});
        step(mk(0,ha,0,0,0,0,0, 0,0,1,e,1,0, 0,2'd0), {tag, ".update"});
        cur_sel = e;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        //              st ha sl ak br jl jr  req irl pce sel bsy flt push pval
        tbl[0]  = mk(1,0,0,0,0,0,0, 0,0,0,2'd0,0,0, 0,2'd0); // IDLE, start sampled
        tbl[1]  = mk(0,0,0,1,0,0,0, 1,1,0,2'd0,1,0, 0,2'd0); // FETCH, ack
        tbl[2]  = mk(0,0,0,0,0,0,0, 0,0,0,2'd0,1,0, 0,2'd0); // DECODE
        tbl[3]  = mk(0,0,0,0,0,0,0, 0,0,0,2'd0,1,0, 1,2'd0); // EXEC incr
        tbl[4]  = mk(0,0,0,0,0,0,0, 0,0,1,2'd0,1,0, 0,2'd0); // UPDATE cycle 4
        tbl[5]  = mk(0,0,0,1,0,0,0, 1,1,0,2'd0,1,0, 0,2'd0);
        tbl[6]  = mk(1,0,0,0,0,0,0, 0,0,0,2'd0,1,0, 0,2'd0); // start ignored
        tbl[7]  = mk(0,0,0,0,1,1,0, 0,0,0,2'd0,1,0, 1,2'd2); // jal beats br
        tbl[8]  = mk(0,0,0,0,0,0,1, 0,0,1,2'd2,1,0, 0,2'd0); // UPDATE cycle 8, jalr ignored
        tbl[9]  = mk(0,0,0,1,0,0,0, 1,1,0,2'd2,1,0, 0,2'd0);
        tbl[10] = mk(0,0,0,0,0,0,0, 0,0,0,2'd2,1,0, 0,2'd0);
        tbl[11] = mk(0,0,0,0,0,1,1, 0,0,0,2'd2,1,0, 1,2'd3); // jalr beats jal
        tbl[12] = mk(0,0,0,0,0,0,0, 0,0,1,2'd3,1,0, 0,2'd0); // UPDATE cycle 12
        tbl[13] = mk(0,0,0,0,0,0,0, 1,0,0,2'd3,1,0, 0,2'd0); // FETCH wait
        tbl[14] = mk(0,0,0,1,0,0,0, 1,1,0,2'd3,1,0, 0,2'd0);
        tbl[15] = mk(0,0,0,0,0,0,0, 0,0,0,2'd3,1,0, 0,2'd0);
        tbl[16] = mk(0,0,1,0,0,1,0, 0,0,0,2'd3,1,0, 0,2'd0); // EXEC stall x3
        tbl[17] = mk(0,0,1,0,0,1,0, 0,0,0,2'd3,1,0, 0,2'd0);
        tbl[18] = mk(0,0,1,0,0,1,0, 0,0,0,2'd3,1,0, 0,2'd0);
        tbl[19] = mk(0,0,0,0,1,0,0, 0,0,0,2'd3,1,0, 1,2'd1); // br only
        tbl[20] = mk(0,0,0,0,0,0,0, 0,0,1,2'd1,1,0, 0,2'd0);
        tbl[21] = mk(0,0,0,1,0,0,0, 1,1,0,2'd1,1,0, 0,2'd0);
        tbl[22] = mk(0,0,1,0,0,0,0, 0,0,0,2'd1,1,0, 0,2'd0); // DECODE stall
        tbl[23] = mk(0,0,0,0,0,0,0, 0,0,0,2'd1,1,0, 0,2'd0);
        tbl[24] = mk(0,1,0,0,0,0,0, 0,0,0,2'd1,1,0, 1,2'd0); // halt ignored in EXEC
        tbl[25] = mk(0,1,0,0,0,0,0, 0,0,1,2'd0,1,0, 0,2'd0); // UPDATE with halt
        tbl[26] = mk(0,0,0,0,0,0,0, 0,0,0,2'd0,0,0, 0,2'd0); // IDLE, busy low
        tbl[27] = mk(1,0,0,0,0,0,0, 0,0,0,2'd0,0,0, 0,2'd0); // resume
        tbl[28] = mk(0,0,1,1,0,0,0, 1,1,0,2'd0,1,0, 0,2'd0); // stall ignored in FETCH
        tbl[29] = mk(0,0,0,0,0,0,0, 0,0,0,2'd0,1,0, 0,2'd0);
        tbl[30] = mk(0,0,0,0,0,0,0, 0,0,0,2'd0,1,0, 1,2'd0);

        bus.start = 0; bus.halt = 0; bus.stall = 0; bus.imem_ack = 0;
        bus.br_taken = 0; bus.jal = 0; bus.jalr = 0;
        exp_ret = '0;
        cur_sel = '0;

        @(negedge clk);
        async_reset("init");

        for (int i = 0; i < 31; i++)
            step(tbl[i], $sformatf("tbl%0d", i));

        // Reset lands in the middle of an UPDATE cycle.
        step(mk(0,0,0,0,0,0,0, 0,0,1,2'd0,1,0, 0,2'd0), "mid_update");
        async_reset("async");

        // Timeout: fifteen unanswered FETCH cycles.
        step(mk(1,0,0,0,0,0,0, 0,0,0,2'd0,0,0, 0,2'd0), "to.idle");
        for (int i = 0; i < 15; i++)
            step(mk(0,0,0,0,0,0,0, 1,0,0,2'd0,1,0, 0,2'd0), $sformatf("to.wait%0d", i));
        for (int i = 0; i < 4; i++)
            step(mk(i[0],0,0,1,0,0,0, 0,0,0,2'd0,0,1, 0,2'd0), $sformatf("to.fault%0d", i));
        @(negedge clk);
        #2;
        async_reset("to.clear");

        // Ack in the fifteenth FETCH cycle still wins.
        step(mk(1,0,0,0,0,0,0, 0,0,0,2'd0,0,0, 0,2'd0), "late.idle");
        for (int i = 0; i < 14; i++)
            step(mk(0,0,0,0,0,0,0, 1,0,0,2'd0,1,0, 0,2'd0), $sformatf("late.wait%0d", i));
        step(mk(0,0,0,1,0,0,0, 1,1,0,2'd0,1,0, 0,2'd0), "late.ack");
        step(mk(0,0,0,0,0,0,0, 0,0,0,2'd0,1,0, 0,2'd0), "late.decode");
        step(mk(0,0,0,0,0,0,1, 0,0,0,2'd0,1,0, 1,2'd3), "late.exec");
        step(mk(0,1,0,0,0,0,0, 0,0,1,2'd3,1,0, 0,2'd0), "late.update");
        step(mk(0,0,0,0,0,0,0, 0,0,0,2'd3,0,0, 0,2'd0), "late.idle2");
        @(negedge clk);
        #2;
        async_reset("wrap.rst");

        // Wrap: seventeen instructions with random redirects and stalls.
        for (int i = 0; i < 17; i++)
            run_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 2),
                      1'b0, (i == 0), $sformatf("wrap%0d", i));
        @(negedge clk);
        #1;
        chk("wrap.retired_final", 32'(bus.retired), 32'd1);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
